// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, flag positions, format limits, FSM states.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RPI = 2'b10,
        RM_RMI = 2'b11
    } rm_t;

    localparam int FLAG_INV = 0;
    localparam int FLAG_DBZ = 1;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 3;
    localparam int FLAG_INX = 4;

    localparam int D_BIAS = 1023;
    localparam int D_EMIN = -1022;
    localparam int D_EMAX = 1023;
    localparam int S_BIAS = 127;
    localparam int S_EMIN = -126;
    localparam int S_EMAX = 127;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_ROUND = 3'd2,
        ST_PACK  = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/fp_pack_round_if.sv
// Operand-in / result-out bundle of the normalise-round-pack stage.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and payload steady until then, and
// ready never depends combinationally on valid.
interface fp_pack_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        s_in;
    logic [12:0] e_in;
    logic [56:0] f_in;
    logic        sticky_in;
    logic        db;
    logic [1:0]  RM;
    logic        nan_in;
    logic        inf_in;
    logic        zero_in;
    logic        inv_in;
    logic        dbz_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] fp_out;
    logic [4:0]  IEEE;

    modport master (
        output in_valid, s_in, e_in, f_in, sticky_in, db, RM,
               nan_in, inf_in, zero_in, inv_in, dbz_in, out_ready,
        input  in_ready, out_valid, fp_out, IEEE
    );

    modport slave (
        input  in_valid, s_in, e_in, f_in, sticky_in, db, RM,
               nan_in, inf_in, zero_in, inv_in, dbz_in, out_ready,
        output in_ready, out_valid, fp_out, IEEE
    );
endinterface

// File: rtl/fp_lzc57.sv
// Combinational leading-zero counter for a 57-bit significand; all-zero gives 57.
module fp_lzc57 (
    input  logic [56:0] f,
    output logic [5:0]  cnt
);
    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt = 6'd57;
        for (int i = 0; i < 57; i++) begin
            if (f[i]) cnt = 6'(56 - i);
        end
    end
endmodule

// File: rtl/fp_pack_round.sv
// Normalise, round and pack an unpacked FP result into binary64 or 2x binary32.
module fp_pack_round
    import fpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fp_pack_round_if.slave     bus,
    output fsm_state_t         dbg_state
);
    fsm_state_t         state_q;
    logic               s_q, db_q, sticky_q, tiny_q, inx_q, zsig_q;
    logic               nan_q, inf_q, zero_q, inv_q, dbz_q;
    rm_t                rm_q;
    logic signed [14:0] e_q;
    logic [56:0]        f_q;
    logic [52:0]        m_q;
    logic               in_ready_q, out_valid_q;
    logic [63:0]        fp_q;
    logic [4:0]         ieee_q;

    logic signed [14:0] emin_c, emax_c;
    logic [5:0]         lz;

    assign emin_c = db_q ? -15'sd1022 : -15'sd126;
    assign emax_c = db_q ? 15'sd1023 : 15'sd127;

    fp_lzc57 u_lzc (.f(f_q), .cnt(lz));

    // NORM: bring the hidden bit to position 55, or denormalise at emin.
    logic [56:0]        f_a, n_f;
    logic signed [14:0] e_a, n_e, room, deficit;
    logic               st_a, n_st, n_tiny;
    logic [5:0]         lshift;
    logic [6:0]         rsh;
    logic [113:0]       wide;

    // Normalisation datapath for the value held in f_q/e_q.
    always_comb begin
        f_a    = f_q;
        e_a    = e_q;
        st_a   = sticky_q;
        lshift = 6'd0;
        room   = e_q - emin_c;
        if (f_q[56]) begin
            f_a  = f_q >> 1;
            st_a = sticky_q | f_q[0];
            e_a  = e_q + 15'sd1;
        end else if (lz != 6'd0 && room > 15'sd0) begin
            lshift = lz - 6'd1;
            if ($signed({9'b0, lshift}) > room) lshift = room[5:0];
            f_a = f_q << lshift;
            e_a = e_q - $signed({9'b0, lshift});
        end
        deficit = emin_c - e_a;
        rsh     = 7'd0;
        if (deficit > 15'sd0) rsh = (deficit > 15'sd57) ? 7'd57 : deficit[6:0];
        wide   = {f_a, 57'b0} >> rsh;
        n_f    = wide[113:57];
        n_st   = st_a | (|wide[56:0]);
        n_e    = (deficit > 15'sd0) ? emin_c : e_a;
        // Tiny before rounding: stuck at emin without a hidden bit.
        n_tiny = (n_e == emin_c) && !n_f[55];
    end

    // ROUND: keep p significant bits, decide increment, absorb carry-out.
    logic [52:0]        r_m, r_mo;
    logic [53:0]        r_sum;
    logic               r_g, r_st, r_inc, r_carry;
    logic signed [14:0] r_eo;

    // Rounding datapath on the normalised significand.
    always_comb begin
        if (db_q) begin
            r_m  = f_q[55:3];
            r_g  = f_q[2];
            r_st = sticky_q | (|f_q[1:0]);
        end else begin
            r_m  = {29'b0, f_q[55:32]};
            r_g  = f_q[31];
            r_st = sticky_q | (|f_q[30:0]);
        end
        case (rm_q)
            RM_RNE:  r_inc = r_g & (r_st | r_m[0]);
            RM_RPI:  r_inc = !s_q & (r_g | r_st);
            RM_RMI:  r_inc = s_q & (r_g | r_st);
            default: r_inc = 1'b0;
        endcase
        r_sum   = {1'b0, r_m} + {53'b0, r_inc};
        r_carry = db_q ? r_sum[53] : r_sum[24];
        r_mo    = r_carry ? r_sum[53:1] : r_sum[52:0];
        r_eo    = r_carry ? e_q + 15'sd1 : e_q;
    end

    // PACK: assemble the output word and exception flags.
    logic [63:0] res;
    logic [4:0]  flg;
    logic [31:0] w32;
    logic [10:0] bexp_d;
    logic [7:0]  bexp_s;
    logic        inf_sel;

    // Result selection by class: NaN > Inf > zero > overflow > finite.
    always_comb begin
        flg           = 5'b0;
        flg[FLAG_INV] = inv_q;
        flg[FLAG_DBZ] = dbz_q;
        inf_sel = (rm_q == RM_RNE) || (rm_q == RM_RPI && !s_q) || (rm_q == RM_RMI && s_q);
        bexp_d  = m_q[52] ? e_q[10:0] + 11'd1023 : 11'd0;
        bexp_s  = m_q[23] ? e_q[7:0] + 8'd127 : 8'd0;
        w32     = 32'b0;
        res     = 64'b0;
        if (nan_q) begin
            res = db_q ? 64'h7FF8000000000000 : 64'h7FC000007FC00000;
        end else if (inf_q) begin
            w32 = {s_q, 8'hFF, 23'b0};
            res = db_q ? {s_q, 11'h7FF, 52'b0} : {w32, w32};
        end else if (zero_q || zsig_q) begin
            w32 = {s_q, 31'b0};
            res = db_q ? {s_q, 63'b0} : {w32, w32};
        end else if (e_q > emax_c) begin
            flg[FLAG_OVF] = 1'b1;
            flg[FLAG_INX] = 1'b1;
            w32 = inf_sel ? {s_q, 8'hFF, 23'b0} : {s_q, 8'hFE, {23{1'b1}}};
            res = db_q ? (inf_sel ? {s_q, 11'h7FF, 52'b0} : {s_q, 11'h7FE, {52{1'b1}}})
                       : {w32, w32};
        end else begin
            flg[FLAG_UNF] = tiny_q & inx_q;
            flg[FLAG_INX] = inx_q;
            w32 = {s_q, bexp_s, m_q[22:0]};
            res = db_q ? {s_q, bexp_d, m_q[51:0]} : {w32, w32};
        end
    end

    // Control FSM and all pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            fp_q        <= 64'b0;
            ieee_q      <= 5'b0;
            s_q         <= 1'b0;
            db_q        <= 1'b0;
            sticky_q    <= 1'b0;
            tiny_q      <= 1'b0;
            inx_q       <= 1'b0;
            zsig_q      <= 1'b0;
            nan_q       <= 1'b0;
            inf_q       <= 1'b0;
            zero_q      <= 1'b0;
            inv_q       <= 1'b0;
            dbz_q       <= 1'b0;
            rm_q        <= RM_RZ;
            e_q         <= 15'sd0;
            f_q         <= 57'b0;
            m_q         <= 53'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        s_q        <= bus.s_in;
                        e_q        <= {{2{bus.e_in[12]}}, bus.e_in};
                        f_q        <= bus.f_in;
                        zsig_q     <= (bus.f_in == 57'b0);
                        sticky_q   <= bus.sticky_in;
                        db_q       <= bus.db;
                        rm_q       <= rm_t'(bus.RM);
                        nan_q      <= bus.nan_in;
                        inf_q      <= bus.inf_in;
                        zero_q     <= bus.zero_in;
                        inv_q      <= bus.inv_in;
                        dbz_q      <= bus.dbz_in;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    f_q      <= n_f;
                    e_q      <= n_e;
                    sticky_q <= n_st;
                    tiny_q   <= n_tiny;
                    state_q  <= ST_ROUND;
                end
                ST_ROUND: begin
                    m_q     <= r_mo;
                    e_q     <= r_eo;
                    inx_q   <= r_g | r_st;
                    state_q <= ST_PACK;
                end
                ST_PACK: begin
                    fp_q        <= res;
                    ieee_q      <= flg;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fp_out    = fp_q;
    assign bus.IEEE      = ieee_q;
    assign dbg_state     = state_q;

endmodule
